// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single DataMemory port between two requesters:
//     port 0 = CPU load/store path, port 1 = debug / program-loader path.
//   Round-robin arbitration with an optional bounded lock for bursts.
//   Each transaction runs IDLE -> SERVE -> DONE: the grant is taken in IDLE,
//   the memory is accessed in SERVE, and the ack pulses in DONE.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   reqN_i                    request, held with stable fields until ackN_o
//   weN_i / stN_i / ldN_i     store enable, StSrc, LdSrc of the request
//   addrN_i / wdataN_i        byte address and store data
//   lockN_i                   owner wants to keep the port for the next access
//   ackN_o                    one-cycle completion pulse
//   rdataN_o                  load result, valid with ackN_o, held until next load
//   mem_*_o / mem_RD_i        DataMemory port (combinational read)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic                  st0_i,
    input  logic                  st1_i,
    input  logic                  ld0_i,
    input  logic                  ld1_i,
    input  logic [DATA_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic                  lock0_i,
    input  logic                  lock1_i,
    output logic                  ack0_o,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  mem_WE_o,
    output logic                  mem_StSrc_o,
    output logic                  mem_LdSrc_o,
    output logic [DATA_WIDTH-1:0] mem_A_o,
    output logic [DATA_WIDTH-1:0] mem_WD_o,
    input  logic [DATA_WIDTH-1:0] mem_RD_i
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  rr_last_q;
    logic                  lock_vld_q;
    logic                  lock_own_q;
    logic [CW-1:0]         lock_cnt_q;
    logic                  ack0_q, ack1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    // The mem_* registers double as the captured request fields; they are
    // loaded on the grant and cleared when SERVE ends.
    logic                  mem_we_q, mem_st_q, mem_ld_q;
    logic [DATA_WIDTH-1:0] mem_a_q, mem_wd_q;

    logic owner_d;      // port selected in IDLE
    logic keep_cnt_d;   // grant is a lock-held regrant; keep lock_cnt
    logic lock_ok_s;    // lock owner is requesting again
    logic other_req_s;  // the non-lock-owner port is requesting

    // Owner selection for the IDLE cycle.
    always_comb begin
        owner_d     = 1'b0;
        keep_cnt_d  = 1'b0;
        lock_ok_s   = lock_vld_q & (lock_own_q ? req1_i : req0_i);
        other_req_s = lock_own_q ? req0_i : req1_i;
        if (lock_ok_s && (lock_cnt_q < LOCK_MAX)) begin
            owner_d    = lock_own_q;
            keep_cnt_d = 1'b1;
        end else if (lock_ok_s && !other_req_s) begin
            // Exhausted but unopposed: regrant, count stays saturated.
            owner_d    = lock_own_q;
            keep_cnt_d = 1'b1;
        end else if (lock_ok_s) begin
            // Exhausted and the other port waits: forced turn.
            owner_d = ~lock_own_q;
        end else if (req0_i && req1_i) begin
            owner_d = ~rr_last_q;
        end else if (req1_i) begin
            owner_d = 1'b1;
        end else begin
            owner_d = 1'b0;
        end
    end

    // Transaction FSM, lock bookkeeping and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            lock_cnt_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_st_q   <= 1'b0;
            mem_ld_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (req0_i || req1_i) begin
                        owner_q  <= owner_d;
                        mem_we_q <= owner_d ? we1_i    : we0_i;
                        mem_st_q <= owner_d ? st1_i    : st0_i;
                        mem_ld_q <= owner_d ? ld1_i    : ld0_i;
                        mem_a_q  <= owner_d ? addr1_i  : addr0_i;
                        mem_wd_q <= owner_d ? wdata1_i : wdata0_i;
                        if (!keep_cnt_d) begin
                            lock_cnt_q <= '0;
                        end
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    if (!mem_we_q) begin
                        if (owner_q) rdata1_q <= mem_RD_i;
                        else         rdata0_q <= mem_RD_i;
                    end
                    ack0_q   <= ~owner_q;
                    ack1_q   <= owner_q;
                    mem_we_q <= 1'b0;
                    mem_st_q <= 1'b0;
                    mem_ld_q <= 1'b0;
                    mem_a_q  <= '0;
                    mem_wd_q <= '0;
                    state_q  <= DONE;
                end
                DONE: begin
                    ack0_q    <= 1'b0;
                    ack1_q    <= 1'b0;
                    rr_last_q <= owner_q;
                    if (owner_q ? lock1_i : lock0_i) begin
                        lock_vld_q <= 1'b1;
                        lock_own_q <= owner_q;
                        // Only regrants under an existing lock count; the
                        // grant that takes the lock starts the count at 0.
                        if (lock_vld_q && (lock_own_q == owner_q)) begin
                            if (lock_cnt_q < LOCK_MAX) begin
                                lock_cnt_q <= lock_cnt_q + CW'(1);
                            end
                        end else begin
                            lock_cnt_q <= '0;
                        end
                    end else begin
                        lock_vld_q <= 1'b0;
                        lock_cnt_q <= '0;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    // Reset gates WE directly so a reset landing in SERVE blocks the write.
    assign mem_WE_o    = mem_we_q & ~rst_i;
    assign mem_StSrc_o = mem_st_q;
    assign mem_LdSrc_o = mem_ld_q;
    assign mem_A_o     = mem_a_q;
    assign mem_WD_o    = mem_wd_q;

endmodule
